// File: rtl/msk_g4mul_hpc1_sched_pkg.sv
// rtl/msk_g4mul_hpc1_sched_pkg.sv - shared constants and width helpers for the HPC1 G(4) multiplier scheduler
package msk_g4mul_hpc1_sched_pkg;

    localparam int DEF_D          = 2;
    localparam int DEF_REF_RNDLAT = 1;
    localparam int DEF_RND_REF_W  = 2;
    localparam int DEF_RND_MUL_W  = 2;
    localparam int DEF_FIFO_DEPTH = 4;

    // The refresh part of the randomness word sits in the low bits, the
    // multiplier part directly above it.
    localparam int RND_REF_LSB = 0;

    function automatic int lat_of(input int ref_rndlat);
        return 2 + ref_rndlat;
    endfunction

    function automatic int rnd_mul_lsb(input int rnd_ref_w);
        return RND_REF_LSB + rnd_ref_w;
    endfunction

    // Counter must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/msk_share_fifo.sv
// rtl/msk_share_fifo.sv - share-wise register FIFO holding 2-bit masked results
// Purpose: stores DEPTH entries of two d-share bit vectors, each share bit in its own flop.
// Ports: clk, rst (sync, active-high), push/in0/in1 write side, pop/out0/out1/not_empty read side.
module msk_share_fifo
    import msk_g4mul_hpc1_sched_pkg::*;
#(
    parameter int d     = DEF_D,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [d-1:0] in0,
    input  logic [d-1:0] in1,
    input  logic         pop,
    output logic [d-1:0] out0,
    output logic [d-1:0] out1,
    output logic         not_empty
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [d-1:0]  mem0 [DEPTH];
    logic [d-1:0]  mem1 [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          pop_ok;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign not_empty = (count != '0);
    assign pop_ok    = pop & not_empty;
    assign out0      = mem0[rd_ptr];
    assign out1      = mem1[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Data storage carries masked shares only and is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem0[wr_ptr] <= in0;
            mem1[wr_ptr] <= in1;
        end
    end

endmodule

// File: rtl/msk_g4mul_hpc1_sched.sv
// rtl/msk_g4mul_hpc1_sched.sv - valid/ready scheduler around a free-running masked HPC1 G(4) multiplier
// Purpose: accepts masked operand pairs plus PRNG words, skews them to the gadget input latencies,
//          tracks results through a LAT-deep valid pipe and buffers them in a credit-bounded FIFO.
// Ports: clk/rst; in_* operand stream; rnd_* PRNG stream; g_* gadget drive/return; out_* result stream.
module msk_g4mul_hpc1_sched
    import msk_g4mul_hpc1_sched_pkg::*;
#(
    parameter int d          = DEF_D,
    parameter int REF_RNDLAT = DEF_REF_RNDLAT,
    parameter int RND_REF_W  = DEF_RND_REF_W,
    parameter int RND_MUL_W  = DEF_RND_MUL_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [d-1:0]                   in_a0,
    input  logic [d-1:0]                   in_a1,
    input  logic [d-1:0]                   in_b0,
    input  logic [d-1:0]                   in_b1,
    input  logic                           rnd_valid,
    output logic                           rnd_ready,
    input  logic [RND_REF_W+RND_MUL_W-1:0] rnd_in,
    output logic [d-1:0]                   g_ina0,
    output logic [d-1:0]                   g_ina1,
    output logic [d-1:0]                   g_inb0,
    output logic [d-1:0]                   g_inb1,
    output logic [RND_REF_W-1:0]           g_rnd_ref,
    output logic [RND_MUL_W-1:0]           g_rnd_mul,
    input  logic [d-1:0]                   g_out0,
    input  logic [d-1:0]                   g_out1,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [d-1:0]                   out_c0,
    output logic [d-1:0]                   out_c1
);

    localparam int LAT     = lat_of(REF_RNDLAT);
    localparam int CW      = cnt_w(FIFO_DEPTH);
    localparam int MUL_LSB = rnd_mul_lsb(RND_REF_W);

    logic [CW-1:0]        cnt;
    logic [LAT-1:0]       vsr;
    logic                 acc;
    logic                 out_fire;
    logic                 b_live;
    logic                 a_live;

    logic [d-1:0]         s1_a0, s1_a1, s1_b0, s1_b1;
    logic [d-1:0]         s2_a0, s2_a1;
    logic [RND_MUL_W-1:0] s1_mul, s2_mul;

    // Credit check uses only cnt, so out_ready never reaches in_ready combinationally.
    assign in_ready  = rnd_valid & (cnt < CW'(FIFO_DEPTH));
    assign acc       = in_valid & in_ready;
    assign rnd_ready = acc;
    assign out_fire  = out_valid & out_ready;

    // vsr[k] is set in the cycle k+1 after an accept; these flags mark the
    // cycles in which the gadget's b and a/rnd_mul inputs must carry the op.
    assign b_live = (REF_RNDLAT == 0) ? acc    : vsr[0];
    assign a_live = (REF_RNDLAT == 0) ? vsr[0] : vsr[1];

    // Every gadget drive is forced to zero outside its live cycle so stale
    // operands or randomness are never replayed into the gadget.
    assign g_rnd_ref = acc    ? rnd_in[RND_REF_LSB +: RND_REF_W] : '0;
    assign g_inb0    = b_live ? ((REF_RNDLAT == 0) ? in_b0 : s1_b0) : '0;
    assign g_inb1    = b_live ? ((REF_RNDLAT == 0) ? in_b1 : s1_b1) : '0;
    assign g_ina0    = a_live ? ((REF_RNDLAT == 0) ? s1_a0 : s2_a0) : '0;
    assign g_ina1    = a_live ? ((REF_RNDLAT == 0) ? s1_a1 : s2_a1) : '0;
    assign g_rnd_mul = a_live ? ((REF_RNDLAT == 0) ? s1_mul : s2_mul) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            vsr <= '0;
            cnt <= '0;
        end else begin
            vsr <= {vsr[LAT-2:0], acc};
            case ({acc, out_fire})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Share-wise delay lines; no reset on data, bubbles load zeros.
    always_ff @(posedge clk) begin
        s1_a0  <= acc ? in_a0 : '0;
        s1_a1  <= acc ? in_a1 : '0;
        s1_b0  <= acc ? in_b0 : '0;
        s1_b1  <= acc ? in_b1 : '0;
        s1_mul <= acc ? rnd_in[MUL_LSB +: RND_MUL_W] : '0;
        s2_a0  <= s1_a0;
        s2_a1  <= s1_a1;
        s2_mul <= s1_mul;
    end

    msk_share_fifo #(
        .d     (d),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (vsr[LAT-1]),
        .in0       (g_out0),
        .in1       (g_out1),
        .pop       (out_ready),
        .out0      (out_c0),
        .out1      (out_c1),
        .not_empty (out_valid)
    );

endmodule
